// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester, UART_TX load and status signals around the arbiter.
// master = arbiter side, slave = requesters plus UART_TX side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_W       = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            REQ;
  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]            GNT;
  logic [DATA_WIDTH-1:0]         P_DATA;
  logic                          Data_Valid;
  logic                          busy;
  logic [ID_W-1:0]               ACTIVE_ID;
  logic [15:0]                   SENT_CNT;
  logic                          ERR;

  modport master (
    input  REQ, REQ_DATA, busy,
    output GNT, P_DATA, Data_Valid, ACTIVE_ID, SENT_CNT, ERR
  );

  modport slave (
    output REQ, REQ_DATA, busy,
    input  GNT, P_DATA, Data_Valid, ACTIVE_ID, SENT_CNT, ERR
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART_TX among NUM_REQ byte producers,
// with busy-rise timeout and optional idle gap between frames.
module uart_tx_arbiter #(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_WIDTH   = 8,
  parameter  int BUSY_TIMEOUT = 4,
  parameter  int GAP_CYCLES   = 0,
  localparam int ID_W         = $clog2(NUM_REQ)
) (
  input logic CLK,
  input logic RST,
  uart_tx_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  state_t          state;
  logic [ID_W-1:0] last;
  logic [15:0]     timer;
  logic [15:0]     gap_cnt;

  logic            pick_ok;
  logic [ID_W-1:0] pick_id;
  logic [ID_W-1:0] cand;

  // Scan from farthest to nearest after LAST so the nearest pending requester wins.
  always_comb begin
    pick_ok = 1'b0;
    pick_id = '0;
    cand    = '0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      cand = ID_W'((32'(last) + k) % NUM_REQ);
      if (bus.REQ[cand]) begin
        pick_ok = 1'b1;
        pick_id = cand;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= IDLE;
      last           <= ID_W'(NUM_REQ - 1);
      timer          <= '0;
      gap_cnt        <= '0;
      bus.GNT        <= '0;
      bus.P_DATA     <= '0;
      bus.Data_Valid <= 1'b0;
      bus.ACTIVE_ID  <= '0;
      bus.SENT_CNT   <= '0;
      bus.ERR        <= 1'b0;
    end else begin
      bus.GNT <= '0;
      bus.ERR <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_ok && !bus.busy) begin
            bus.P_DATA     <= bus.REQ_DATA[32'(pick_id)*DATA_WIDTH +: DATA_WIDTH];
            bus.Data_Valid <= 1'b1;
            bus.GNT        <= NUM_REQ'(1) << pick_id;
            bus.ACTIVE_ID  <= pick_id;
            last           <= pick_id;
            timer          <= '0;
            state          <= LOAD;
          end
        end
        LOAD: begin
          if (bus.busy) begin
            bus.Data_Valid <= 1'b0;
            state          <= SEND;
          end else if (timer == 16'(BUSY_TIMEOUT - 1)) begin
            // Byte is dropped; LAST already points at this requester.
            bus.Data_Valid <= 1'b0;
            bus.ERR        <= 1'b1;
            state          <= IDLE;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        SEND: begin
          if (!bus.busy) begin
            bus.SENT_CNT <= bus.SENT_CNT + 16'd1;
            if (GAP_CYCLES > 0) begin
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 16'(GAP_CYCLES - 1)) state <= IDLE;
          else gap_cnt <= gap_cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: per-requester byte queues, a round-robin
// expectation model and a behavioural UART_TX busy responder.
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int W     = 8;
  localparam int TO    = 4;
  localparam int GAP   = 3;
  localparam int FRAME = 11;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(W)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(W), .BUSY_TIMEOUT(TO), .GAP_CYCLES(GAP)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  // UART_TX stand-in: accepts a load strobe, stays busy FRAME cycles, logs the byte
  logic         uart_en = 1'b1;
  int unsigned  busy_left = 0;
  logic [W-1:0] cap_mem [256];
  int unsigned  cap_n = 0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus.busy  <= 1'b0;
      busy_left <= 0;
    end else if (!uart_en) begin
      bus.busy <= 1'b0;
    end else if (busy_left != 0) begin
      busy_left <= busy_left - 1;
      if (busy_left == 1) bus.busy <= 1'b0;
    end else if (bus.Data_Valid) begin
      bus.busy              <= 1'b1;
      busy_left             <= FRAME;
      cap_mem[cap_n % 256]  <= bus.P_DATA;
      cap_n                 <= cap_n + 1;
    end
  end

  // Reference model state
  logic [W-1:0] pend [N][32];
  int unsigned  hd [N];
  int unsigned  tl [N];
  int unsigned  m_last, m_sent, pend_frames;
  logic [W-1:0] exp_b [256];
  int unsigned  exp_n, cap_base;
  int checks = 0;
  int errors = 0;

  task automatic drive_req();
    for (int unsigned i = 0; i < N; i++) begin
      bus.REQ[i] = (hd[i] != tl[i]);
      bus.REQ_DATA[i*W +: W] = (hd[i] != tl[i]) ? pend[i][hd[i] % 32] : W'($urandom);
    end
  endtask

  task automatic push(input int unsigned i, input logic [W-1:0] b);
    pend[i][tl[i] % 32] = b;
    tl[i]++;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; end
    m_last = N - 1; m_sent = 0; exp_n = 0; pend_frames = 0;
    drive_req();
    @(negedge CLK);
    @(negedge CLK);
    cap_base = cap_n;
  endtask

  // Called at a negedge where GNT is high: compare against the round-robin choice
  task automatic serve_grant();
    int unsigned e;
    e = N;
    for (int unsigned k = 1; k <= N; k++) begin
      if (hd[(m_last + k) % N] != tl[(m_last + k) % N]) begin
        e = (m_last + k) % N;
        break;
      end
    end
    checks++;
    if (e == N) begin
      errors++;
      $display("FAIL unexpected_grant GNT=%b with nothing pending", bus.GNT);
    end else begin
      checks++;
      if (bus.GNT !== N'(1 << e)) begin
        errors++; $display("FAIL gnt got=%b exp=%b", bus.GNT, N'(1 << e));
      end
      checks++;
      if (bus.P_DATA !== pend[e][hd[e] % 32]) begin
        errors++; $display("FAIL p_data got=%h exp=%h", bus.P_DATA, pend[e][hd[e] % 32]);
      end
      checks++;
      if (bus.ACTIVE_ID !== 2'(e)) begin
        errors++; $display("FAIL active_id got=%0d exp=%0d", bus.ACTIVE_ID, e);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++; $display("FAIL gnt_during_busy busy=%b exp=0", bus.busy);
      end
      exp_b[exp_n % 256] = pend[e][hd[e] % 32];
      exp_n++;
      hd[e]++;
      m_last = e;
      pend_frames++;
    end
    drive_req();
  endtask

  task automatic drain();
    int unsigned idle = 0;
    int unsigned cyc = 0;
    while (idle < GAP + 4 && cyc < 400) begin
      @(negedge CLK);
      cyc++;
      if (bus.GNT != '0) serve_grant();
      if (bus.busy === 1'b0 && bus.Data_Valid === 1'b0) idle++;
      else idle = 0;
    end
    checks++;
    if (idle < GAP + 4) begin
      errors++; $display("FAIL drain_timeout idle=%0d exp>=%0d", idle, GAP + 4);
    end
    if (uart_en) m_sent += pend_frames;
    pend_frames = 0;
    checks++;
    if (bus.SENT_CNT !== 16'(m_sent)) begin
      errors++; $display("FAIL sent_cnt got=%0d exp=%0d", bus.SENT_CNT, m_sent);
    end
    checks++;
    if (cap_n - cap_base != exp_n) begin
      errors++; $display("FAIL uart_bytes got=%0d exp=%0d", cap_n - cap_base, exp_n);
    end else begin
      for (int unsigned j = 0; j < exp_n; j++) begin
        checks++;
        if (cap_mem[(cap_base + j) % 256] !== exp_b[j % 256]) begin
          errors++;
          $display("FAIL uart_byte[%0d] got=%h exp=%h", j, cap_mem[(cap_base + j) % 256], exp_b[j % 256]);
        end
      end
    end
  endtask

  task automatic run_frames(input int unsigned n);
    int unsigned got = 0;
    int unsigned cyc = 0;
    while (got < n && cyc < n * 60 + 60) begin
      @(negedge CLK);
      cyc++;
      if (bus.GNT != '0) begin
        serve_grant();
        got++;
      end
    end
    checks++;
    if (got < n) begin
      errors++; $display("FAIL grant_count got=%0d exp=%0d", got, n);
    end
    drain();
  endtask

  task automatic test_reset();
    do_reset();
    for (int unsigned i = 0; i < N; i++) push(i, W'($urandom));
    drive_req();
    @(negedge CLK);
    checks++;
    if (bus.GNT !== '0 || bus.Data_Valid !== 1'b0 || bus.SENT_CNT !== 16'd0 || bus.ERR !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got GNT=%b DV=%b CNT=%0d ERR=%b exp 0", bus.GNT, bus.Data_Valid, bus.SENT_CNT, bus.ERR);
    end
    checks++;
    if (bus.P_DATA !== '0 || bus.ACTIVE_ID !== '0) begin
      errors++; $display("FAIL reset_data got P_DATA=%h ID=%0d exp 0", bus.P_DATA, bus.ACTIVE_ID);
    end
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.GNT !== 4'b0001) begin
      errors++; $display("FAIL first_grant got=%b exp=0001", bus.GNT);
    end
    serve_grant();
    run_frames(N - 1);
  endtask

  task automatic test_single();
    do_reset();
    push(2, 8'hA5);
    drive_req();
    RST = 1'b1;
    run_frames(1);
  endtask

  task automatic test_fairness();
    do_reset();
    push(0, 8'h11); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44); push(0, 8'h55);
    drive_req();
    RST = 1'b1;
    run_frames(5);
  endtask

  task automatic test_back_to_back();
    for (int unsigned k = 0; k < 4; k++) push(1, W'($urandom));
    drive_req();
    run_frames(4);
  endtask

  task automatic test_random();
    for (int unsigned r = 0; r < 6; r++) begin
      int unsigned total = 0;
      for (int unsigned i = 0; i < N; i++) begin
        int unsigned c = $urandom_range(0, 3);
        for (int unsigned k = 0; k < c; k++) push(i, W'($urandom));
        total += c;
      end
      if (total == 0) begin
        push($urandom_range(0, N - 1), W'($urandom));
        total = 1;
      end
      drive_req();
      run_frames(total);
    end
  endtask

  // GAP+2 quiet cycles: the cycle busy is seen low, GAP idle cycles, one grant decision
  task automatic test_gap();
    int unsigned cyc = 0;
    int unsigned cnt = 0;
    do_reset();
    push(0, W'($urandom)); push(0, W'($urandom));
    drive_req();
    RST = 1'b1;
    while (bus.GNT == '0 && cyc < 20) begin @(negedge CLK); cyc++; end
    if (bus.GNT != '0) serve_grant();
    cyc = 0;
    while (bus.busy !== 1'b1 && cyc < 20) begin @(negedge CLK); cyc++; end
    cyc = 0;
    while (bus.busy !== 1'b0 && cyc < 40) begin @(negedge CLK); cyc++; end
    cyc = 0;
    while (bus.Data_Valid !== 1'b1 && cyc < 50) begin
      cnt++; cyc++;
      @(negedge CLK);
      if (bus.GNT != '0) serve_grant();
    end
    checks++;
    if (cnt != GAP + 2) begin
      errors++; $display("FAIL gap_cycles got=%0d exp=%0d", cnt, GAP + 2);
    end
    drain();
  endtask

  task automatic test_timeout();
    int unsigned cyc = 0;
    int unsigned dv = 0;
    do_reset();
    uart_en = 1'b0;
    push(1, W'($urandom)); push(2, W'($urandom));
    drive_req();
    RST = 1'b1;
    while (bus.GNT == '0 && cyc < 20) begin @(negedge CLK); cyc++; end
    checks++;
    if (bus.GNT !== 4'b0010) begin
      errors++; $display("FAIL timeout_gnt got=%b exp=0010", bus.GNT);
    end
    if (bus.GNT != '0) serve_grant();
    cyc = 0;
    while (bus.Data_Valid === 1'b1 && cyc < 20) begin dv++; cyc++; @(negedge CLK); end
    checks++;
    if (dv != TO) begin
      errors++; $display("FAIL dv_high_cycles got=%0d exp=%0d", dv, TO);
    end
    checks++;
    if (bus.ERR !== 1'b1) begin
      errors++; $display("FAIL err_pulse got=%b exp=1", bus.ERR);
    end
    @(negedge CLK);
    checks++;
    if (bus.ERR !== 1'b0) begin
      errors++; $display("FAIL err_width got=%b exp=0", bus.ERR);
    end
    checks++;
    if (bus.GNT !== 4'b0100) begin
      errors++; $display("FAIL next_after_timeout got=%b exp=0100", bus.GNT);
    end
    if (bus.GNT != '0) serve_grant();
    repeat (TO + 3) @(negedge CLK);
    checks++;
    if (bus.SENT_CNT !== 16'd0) begin
      errors++; $display("FAIL timeout_sent got=%0d exp=0", bus.SENT_CNT);
    end
    do_reset();
    uart_en = 1'b1;
  endtask

  task automatic test_abort();
    int unsigned cyc = 0;
    do_reset();
    push(0, W'($urandom));
    drive_req();
    RST = 1'b1;
    while (bus.GNT == '0 && cyc < 20) begin @(negedge CLK); cyc++; end
    if (bus.GNT != '0) serve_grant();
    cyc = 0;
    while (bus.busy !== 1'b1 && cyc < 20) begin @(negedge CLK); cyc++; end
    repeat (4) @(negedge CLK);
    do_reset();
    checks++;
    if (bus.GNT !== '0 || bus.Data_Valid !== 1'b0 || bus.P_DATA !== '0 ||
        bus.ACTIVE_ID !== '0 || bus.SENT_CNT !== 16'd0 || bus.ERR !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs got GNT=%b DV=%b P=%h ID=%0d CNT=%0d ERR=%b exp 0",
               bus.GNT, bus.Data_Valid, bus.P_DATA, bus.ACTIVE_ID, bus.SENT_CNT, bus.ERR);
    end
    push(0, W'($urandom)); push(3, W'($urandom));
    drive_req();
    RST = 1'b1;
    run_frames(2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.REQ = '0;
    bus.REQ_DATA = '0;
    test_reset();
    test_single();
    test_fairness();
    test_back_to_back();
    test_random();
    test_gap();
    test_timeout();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
